rgb_point_op: RTL and testbench

Parametrised per-pixel point-operation stage for the camera video path. It sits between the capture front end and the frame buffer writer. Each pixel gets one of four operations: pass-through, colour inversion, saturating brightness offset, or luma binary threshold. Configuration is shadowed at frame start so a frame is never processed with mixed settings. Data and sync strobes come out through a fixed 2-stage registered pipeline.

---
 rtl/rgb_point_op.sv | 223 ++++++++++++++++++++++
 tb/tb_rgb_point_op.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rgb_point_op.sv
// rgb_point_op: per-pixel point operation (pass / invert / saturating offset / luma threshold)
// with frame-start config shadowing and a fixed 2-stage pipeline. Thresholding needs `RGB_POINT_THRESH_EN.
module rgb_point_op #(
  parameter  int R_W   = 5,
  parameter  int G_W   = 6,
  parameter  int B_W   = 5,
  parameter  int OFS_W = 7,
  localparam int PIX_W = R_W + G_W + B_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       cfg_mode,
  input  logic [OFS_W-1:0] cfg_offset,
  input  logic [7:0]       cfg_thresh,
  input  logic             per_frame_vsync,
  input  logic             per_frame_href,
  input  logic             per_frame_clken,
  input  logic [PIX_W-1:0] per_img,
  output logic             post_frame_vsync,
  output logic             post_frame_href,
  output logic             post_frame_clken,
  output logic [PIX_W-1:0] post_img,
  output logic [1:0]       active_mode
);

  localparam int SR_W = ((R_W > OFS_W) ? R_W : OFS_W) + 2;
  localparam int SG_W = ((G_W > OFS_W) ? G_W : OFS_W) + 2;
  localparam int SB_W = ((B_W > OFS_W) ? B_W : OFS_W) + 2;

  // Replicate a w-bit channel's own MSBs downward to fill an 8-bit code.
  function automatic logic [7:0] widen8(input logic [7:0] c, input int w);
    logic [7:0] res;
    res = 8'd0;
    for (int i = 0; i < 8; i++) begin
      res[7-i] = c[w-1-(i % w)];
    end
    return res;
  endfunction

  logic             vs_d_r;
  logic             frame_start_s;
  logic [1:0]       mode_r;
  logic [OFS_W-1:0] offset_r;

  logic [R_W-1:0]   r_in_s;
  logic [G_W-1:0]   g_in_s;
  logic [B_W-1:0]   b_in_s;
  logic [SR_W-1:0]  sum_r_s;
  logic [SG_W-1:0]  sum_g_s;
  logic [SB_W-1:0]  sum_b_s;

  logic [PIX_W-1:0] pix_s1_r;
  logic             hs_s1_r;
  logic             ck_s1_r;
  logic [1:0]       mode_s1_r;
  logic [SR_W-1:0]  sum_r_s1_r;
  logic [SG_W-1:0]  sum_g_s1_r;
  logic [SB_W-1:0]  sum_b_s1_r;

  logic [R_W-1:0]   ofs_r_s;
  logic [G_W-1:0]   ofs_g_s;
  logic [B_W-1:0]   ofs_b_s;
  logic [PIX_W-1:0] result_s;

  logic [PIX_W-1:0] img_s2_r;
  logic             vs_s2_r;
  logic             hs_s2_r;
  logic             ck_s2_r;

`ifdef RGB_POINT_THRESH_EN
  logic [7:0]       thresh_r;
  logic [7:0]       thresh_s1_r;
  logic [7:0]       y8_s;
  logic [7:0]       y8_s1_r;
  logic [7:0]       luma_frac_unused_s;
  logic [7:0]       r8_s;
  logic [7:0]       g8_s;
  logic [7:0]       b8_s;
`else
  logic             unused_thresh_s;
  assign unused_thresh_s = ^cfg_thresh;
`endif

  assign frame_start_s = per_frame_vsync & ~vs_d_r;

  assign r_in_s = per_img[PIX_W-1 -: R_W];
  assign g_in_s = per_img[B_W +: G_W];
  assign b_in_s = per_img[0 +: B_W];

  // Offset is added in a widened two's-complement domain so the sign survives for clamping.
  assign sum_r_s = {{(SR_W-R_W){1'b0}}, r_in_s} + {{(SR_W-OFS_W){offset_r[OFS_W-1]}}, offset_r};
  assign sum_g_s = {{(SG_W-G_W){1'b0}}, g_in_s} + {{(SG_W-OFS_W){offset_r[OFS_W-1]}}, offset_r};
  assign sum_b_s = {{(SB_W-B_W){1'b0}}, b_in_s} + {{(SB_W-OFS_W){offset_r[OFS_W-1]}}, offset_r};

`ifdef RGB_POINT_THRESH_EN
  assign r8_s = widen8(8'(r_in_s), R_W);
  assign g8_s = widen8(8'(g_in_s), G_W);
  assign b8_s = widen8(8'(b_in_s), B_W);
  assign {y8_s, luma_frac_unused_s} = 16'd77 * 16'(r8_s) + 16'd150 * 16'(g8_s) + 16'd29 * 16'(b8_s);
`endif

  // Frame-start edge detector and configuration shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d_r   <= 1'b0;
      mode_r   <= 2'd0;
      offset_r <= {OFS_W{1'b0}};
`ifdef RGB_POINT_THRESH_EN
      thresh_r <= 8'd128;
`endif
    end else begin
      vs_d_r <= per_frame_vsync;
      if (frame_start_s) begin
        mode_r   <= cfg_mode;
        offset_r <= cfg_offset;
`ifdef RGB_POINT_THRESH_EN
        thresh_r <= cfg_thresh;
`endif
      end
    end
  end

  // Stage 1: capture pixel, syncs, offset sums and luma; the mode travels with the pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_s1_r    <= {PIX_W{1'b0}};
      hs_s1_r     <= 1'b0;
      ck_s1_r     <= 1'b0;
      mode_s1_r   <= 2'd0;
      sum_r_s1_r  <= {SR_W{1'b0}};
      sum_g_s1_r  <= {SG_W{1'b0}};
      sum_b_s1_r  <= {SB_W{1'b0}};
`ifdef RGB_POINT_THRESH_EN
      y8_s1_r     <= 8'd0;
      thresh_s1_r <= 8'd0;
`endif
    end else begin
      pix_s1_r    <= per_img;
      hs_s1_r     <= per_frame_href;
      ck_s1_r     <= per_frame_clken;
      mode_s1_r   <= mode_r;
      sum_r_s1_r  <= sum_r_s;
      sum_g_s1_r  <= sum_g_s;
      sum_b_s1_r  <= sum_b_s;
`ifdef RGB_POINT_THRESH_EN
      y8_s1_r     <= y8_s;
      thresh_s1_r <= thresh_r;
`endif
    end
  end

  // Clamp each offset sum: sign bit set -> 0, any bit above the channel width -> full scale.
  always_comb begin
    ofs_r_s = {R_W{1'b0}};
    ofs_g_s = {G_W{1'b0}};
    ofs_b_s = {B_W{1'b0}};
    if (sum_r_s1_r[SR_W-1]) begin
      ofs_r_s = {R_W{1'b0}};
    end else if (|sum_r_s1_r[SR_W-2:R_W]) begin
      ofs_r_s = {R_W{1'b1}};
    end else begin
      ofs_r_s = sum_r_s1_r[R_W-1:0];
    end
    if (sum_g_s1_r[SG_W-1]) begin
      ofs_g_s = {G_W{1'b0}};
    end else if (|sum_g_s1_r[SG_W-2:G_W]) begin
      ofs_g_s = {G_W{1'b1}};
    end else begin
      ofs_g_s = sum_g_s1_r[G_W-1:0];
    end
    if (sum_b_s1_r[SB_W-1]) begin
      ofs_b_s = {B_W{1'b0}};
    end else if (|sum_b_s1_r[SB_W-2:B_W]) begin
      ofs_b_s = {B_W{1'b1}};
    end else begin
      ofs_b_s = sum_b_s1_r[B_W-1:0];
    end
  end

  // Mode-selected result for stage 2.
  always_comb begin
    result_s = pix_s1_r;
    case (mode_s1_r)
      2'd0: result_s = pix_s1_r;
      2'd1: result_s = ~pix_s1_r;
      2'd2: result_s = {ofs_r_s, ofs_g_s, ofs_b_s};
`ifdef RGB_POINT_THRESH_EN
      2'd3: begin
        if (y8_s1_r >= thresh_s1_r) begin
          result_s = {PIX_W{1'b1}};
        end else begin
          result_s = {PIX_W{1'b0}};
        end
      end
`else
      2'd3: result_s = pix_s1_r;
`endif
      default: result_s = pix_s1_r;
    endcase
  end

  // Stage 2: registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      img_s2_r <= {PIX_W{1'b0}};
      vs_s2_r  <= 1'b0;
      hs_s2_r  <= 1'b0;
      ck_s2_r  <= 1'b0;
    end else begin
      img_s2_r <= result_s;
      vs_s2_r  <= vs_d_r;
      hs_s2_r  <= hs_s1_r;
      ck_s2_r  <= ck_s1_r;
    end
  end

  assign post_img         = img_s2_r;
  assign post_frame_vsync = vs_s2_r;
  assign post_frame_href  = hs_s2_r;
  assign post_frame_clken = ck_s2_r;
  assign active_mode      = mode_r;

endmodule

// File: tb/tb_rgb_point_op.sv
// Scoreboard bench for rgb_point_op (default parameters); honours `RGB_POINT_THRESH_EN when defined.
module tb_rgb_point_op;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cfg_mode;
  logic [6:0]  cfg_offset;
  logic [7:0]  cfg_thresh;
  logic        per_frame_vsync;
  logic        per_frame_href;
  logic        per_frame_clken;
  logic [15:0] per_img;
  logic        post_frame_vsync;
  logic        post_frame_href;
  logic        post_frame_clken;
  logic [15:0] post_img;
  logic [1:0]  active_mode;

  rgb_point_op dut (
    .clk(clk), .rst(rst),
    .cfg_mode(cfg_mode), .cfg_offset(cfg_offset), .cfg_thresh(cfg_thresh),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken), .per_img(per_img),
    .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
    .post_frame_clken(post_frame_clken), .post_img(post_img),
    .active_mode(active_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] img;
    int          due;
  } exp_t;

  exp_t       sb_q[$];
  int         errors = 0;
  int         checks = 0;
  int         edge_n = 0;
  logic [1:0] m_mode = 2'd0;
  int         m_ofs  = 0;
  logic [7:0] m_thr  = 8'd128;
  logic       m_vsd  = 1'b0;
  logic [2:0] m_s1   = 3'd0;
  logic [2:0] m_s2   = 3'd0;
  logic       m_z1   = 1'b1;
  logic       m_z2   = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int sat(input int x, input int mx);
    return (x < 0) ? 0 : ((x > mx) ? mx : x);
  endfunction

  // Reference model written directly from the channel formulas (RGB565 layout).
  function automatic logic [15:0] model_pix(input logic [15:0] p, input logic [1:0] md,
                                            input int ofs, input logic [7:0] thr);
    int r, g, b, y;
    logic [15:0] res;
    r = int'(p[15:11]);
    g = int'(p[10:5]);
    b = int'(p[4:0]);
    y = 0;
    res = p;
    case (md)
      2'd1: res = 16'hFFFF - p;
      2'd2: res = {5'(sat(r + ofs, 31)), 6'(sat(g + ofs, 63)), 5'(sat(b + ofs, 31))};
      2'd3: begin
`ifdef RGB_POINT_THRESH_EN
        y = (77 * ((r << 3) | (r >> 2)) + 150 * ((g << 2) | (g >> 4)) + 29 * ((b << 3) | (b >> 2))) >> 8;
        res = (y >= int'(thr)) ? 16'hFFFF : 16'h0000;
`else
        res = p;
`endif
      end
      default: res = p;
    endcase
    return res;
  endfunction

  // One clock: drive inputs, advance the model, then check outputs on the falling edge.
  task automatic step_core(input logic v, input logic h, input logic c, input logic [15:0] p,
                           input logic directed, input logic [15:0] dexp);
    exp_t e;
    per_frame_vsync = v;
    per_frame_href  = h;
    per_frame_clken = c;
    per_img         = p;
    if (rst) begin
      sb_q.delete();
      m_mode = 2'd0; m_ofs = 0; m_thr = 8'd128; m_vsd = 1'b0;
      m_s1 = 3'd0; m_s2 = 3'd0; m_z1 = 1'b1; m_z2 = 1'b1;
    end else begin
      if (c) begin
        e.img = directed ? dexp : model_pix(p, m_mode, m_ofs, m_thr);
        e.due = edge_n + 2;
        sb_q.push_back(e);
      end
      if (v && !m_vsd) begin
        m_mode = cfg_mode;
        m_ofs  = int'($signed(cfg_offset));
        m_thr  = cfg_thresh;
      end
      m_vsd = v;
      m_s2 = m_s1; m_z2 = m_z1;
      m_s1 = {v, h, c}; m_z1 = 1'b0;
    end
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    check_eq("active_mode", 32'(active_mode), 32'(m_mode));
    check_eq("syncs", 32'({post_frame_vsync, post_frame_href, post_frame_clken}), 32'(m_s2));
    if (m_z2) check_eq("img_flushed", 32'(post_img), 32'd0);
    if (post_frame_clken) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_clken", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("latency", 32'(edge_n), 32'(e.due));
        check_eq("post_img", 32'(post_img), 32'(e.img));
      end
    end else if (sb_q.size() > 0 && sb_q[0].due <= edge_n) begin
      e = sb_q.pop_front();
      check_eq("missing_clken", 32'd0, 32'd1);
    end
  endtask

  task automatic step(input logic v, input logic h, input logic c, input logic [15:0] p);
    step_core(v, h, c, p, 1'b0, 16'h0000);
  endtask

  task automatic step_x(input logic v, input logic h, input logic c, input logic [15:0] p,
                        input logic [15:0] dexp);
    step_core(v, h, c, p, 1'b1, dexp);
  endtask

  task automatic new_frame();
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic rand_pixels(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom));
  endtask

  initial begin
    rst = 1'b1; cfg_mode = 2'd1; cfg_offset = 7'd0; cfg_thresh = 8'd0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'h0000);
    rst = 1'b0;

    // vsync already high at the first edge out of reset counts as a frame start
    step(1'b1, 1'b1, 1'b1, 16'h1111);
    step_x(1'b1, 1'b1, 1'b1, 16'hF800, 16'h07FF);
    rand_pixels(4);

    cfg_mode = 2'd2; cfg_offset = 7'd4;
    new_frame();
    step_x(1'b1, 1'b1, 1'b1, 16'hF81F, 16'hF89F);
    rand_pixels(4);
    cfg_offset = 7'h78;
    new_frame();
    step_x(1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000);
    rand_pixels(4);

    cfg_mode = 2'd3; cfg_thresh = 8'd130;
    new_frame();
`ifdef RGB_POINT_THRESH_EN
    step_x(1'b1, 1'b1, 1'b1, 16'h8410, 16'hFFFF);
`else
    step_x(1'b1, 1'b1, 1'b1, 16'h8410, 16'h8410);
`endif
    rand_pixels(4);
    cfg_thresh = 8'd131;
    new_frame();
`ifdef RGB_POINT_THRESH_EN
    step_x(1'b1, 1'b1, 1'b1, 16'h8410, 16'h0000);
`else
    step_x(1'b1, 1'b1, 1'b1, 16'h8410, 16'h8410);
`endif

    // Mid-frame config change must not take effect until the next frame start
    cfg_mode = 2'd0;
    new_frame();
    rand_pixels(2);
    cfg_mode = 2'd1;
    rand_pixels(3);
    step_x(1'b1, 1'b1, 1'b1, 16'h1234, 16'h1234);
    new_frame();
    step_x(1'b1, 1'b1, 1'b1, 16'h0000, 16'hFFFF);
    rand_pixels(3);

    // Mid-frame reset flushes the pipe and restores mode 0
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 16'h1234);
    rst = 1'b1;
    step(1'b0, 1'b1, 1'b1, 16'h1234);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 16'h1234);
    step_x(1'b0, 1'b1, 1'b1, 16'h1234, 16'h1234);

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'h0000);
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
